// File: rtl/serial_adder_pkg.sv
// Shared types and defaults for the bit-serial adder.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/full_adder.sv
// Single-bit combinational full adder; the only arithmetic cell of the serial adder.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full_adder cell plus a registered carry, LSB first.
// Define SERIAL_ADDER_OVF_EN to add the registered two's-complement overflow output ovf.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADDER_OVF_EN
  output logic             ovf,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic             carry_q, carry_d;
  logic [CNT_W-1:0] count_q, count_d;
  // Only WIDTH-1 bits are kept; the final edge's bit completes the word directly.
  logic [WIDTH-2:0] sum_sh_q, sum_sh_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic [WIDTH-1:0] sum_next;
  logic             fa_sum, fa_cout;
`ifdef SERIAL_ADDER_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  full_adder u_fa (
    .a    (a_sh_q[0]),
    .b    (b_sh_q[0]),
    .cin  (carry_q),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    carry_d  = carry_q;
    count_d  = count_q;
    sum_sh_d = sum_sh_q;
    sum_d    = sum_q;
    cout_d   = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
    ovf_d    = ovf_q;
`endif
    sum_next = {fa_sum, sum_sh_q};

    case (state_q)
      IDLE: begin
        if (start) begin
          a_sh_d  = a;
          b_sh_d  = b;
          carry_d = cin;
          count_d = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        a_sh_d   = {1'b0, a_sh_q[WIDTH-1:1]};
        b_sh_d   = {1'b0, b_sh_q[WIDTH-1:1]};
        carry_d  = fa_cout;
        count_d  = count_q + 1'b1;
        sum_sh_d = sum_next[WIDTH-1:1];
        if (count_q == LAST) begin
          sum_d   = sum_next;
          cout_d  = fa_cout;
`ifdef SERIAL_ADDER_OVF_EN
          // On the MSB edge carry_q is the carry into the MSB.
          ovf_d   = carry_q ^ fa_cout;
`endif
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      carry_q  <= 1'b0;
      count_q  <= '0;
      sum_sh_q <= '0;
      sum_q    <= '0;
      cout_q   <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      carry_q  <= carry_d;
      count_q  <= count_d;
      sum_sh_q <= sum_sh_d;
      sum_q    <= sum_d;
      cout_q   <= cout_d;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q    <= ovf_d;
`endif
    end
  end

  assign busy = (state_q == SHIFT);
  assign done = (state_q == DONE);
  assign sum  = sum_q;
  assign cout = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
  assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Table-driven, scoreboard-checked bench for serial_adder (WIDTH=8).
module tb_serial_adder;

  localparam int W = 8;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } vec_t;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } exp_t;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
`ifdef SERIAL_ADDER_OVF_EN
  logic         ovf;
`endif

  int total;
  int bad;
  int done_count;
  exp_t sbq[$];
  logic [W-1:0] last_sum;
  logic         last_cout;

  serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
`ifdef SERIAL_ADDER_OVF_EN
    .ovf   (ovf),
`endif
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && done) begin
      exp_t e;
      done_count++;
      if (sbq.size() == 0) begin
        checkOutput("unexpected_done", 32'd1, 32'd0);
      end else begin
        e = sbq.pop_front();
        checkOutput("sum", 32'(sum), 32'(e.sum));
        checkOutput("cout", 32'(cout), 32'(e.cout));
`ifdef SERIAL_ADDER_OVF_EN
        checkOutput("ovf", 32'(ovf), 32'(e.ovf));
`endif
      end
    end
  end

  // Issue one add, check busy length, held outputs and the done pulse.
  task automatic applyStimulus(input logic [W-1:0] va, input logic [W-1:0] vb, input logic vcin,
                               input logic [W-1:0] esum, input logic ecout, input logic eovf,
                               input bit inject);
    exp_t e;
    int n;
    @(negedge clk);
    a = va; b = vb; cin = vcin; start = 1'b1;
    e.sum = esum; e.cout = ecout; e.ovf = eovf;
    sbq.push_back(e);
    @(negedge clk);
    start = 1'b0;
    a = ~va; b = ~vb; cin = ~vcin;
    checkOutput("busy_rise", 32'(busy), 32'd1);
    n = 0;
    while (busy && n < 100) begin
      n++;
      checkOutput("hold_sum", 32'(sum), 32'(last_sum));
      checkOutput("hold_cout", 32'(cout), 32'(last_cout));
      if (inject && n == 3) begin
        start = 1'b1; a = 8'hFF; b = 8'hFF;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    checkOutput("busy_cycles", 32'(n), 32'(W));
    checkOutput("done_pulse", 32'(done), 32'd1);
    @(negedge clk);
    checkOutput("done_low", 32'(done), 32'd0);
    checkOutput("idle_after", 32'(busy), 32'd0);
    last_sum  = esum;
    last_cout = ecout;
  endtask

  initial begin
    vec_t vecs[7];
    int dc;
    logic [W:0] full;
    logic [W-1:0] ra, rb;
    logic rc;

    vecs[0] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[2] = '{8'h3C, 8'h0F, 1'b1, 8'h4C, 1'b0, 1'b0};
    vecs[3] = '{8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1, 1'b0};
    vecs[4] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
    vecs[5] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
    vecs[6] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};

    total = 0; bad = 0; done_count = 0;
    last_sum = '0; last_cout = 1'b0;
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    #1;
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_sum", 32'(sum), 32'd0);
    checkOutput("rst_cout", 32'(cout), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++)
      applyStimulus(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sum, vecs[i].cout, vecs[i].ovf, 1'b0);

    for (int i = 0; i < 4; i++) begin
      ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom);
      full = {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rc};
      applyStimulus(ra, rb, rc, full[W-1:0], full[W],
                    (ra[W-1] == rb[W-1]) && (full[W-1] != ra[W-1]), 1'b0);
    end

    // Start re-asserted while busy must be dropped, not queued.
    dc = done_count;
    applyStimulus(8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0, 1'b1);
    repeat (3) @(negedge clk);
    checkOutput("no_queued_start", 32'(busy), 32'd0);
    checkOutput("single_done", 32'(done_count - dc), 32'd1);

    // Reset after the 4th SHIFT edge aborts without a done.
    dc = done_count;
    @(negedge clk);
    a = 8'hAA; b = 8'h11; cin = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("abort_sum", 32'(sum), 32'd0);
    checkOutput("abort_cout", 32'(cout), 32'd0);
    checkOutput("abort_busy", 32'(busy), 32'd0);
    checkOutput("abort_done", 32'(done), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    checkOutput("abort_no_done", 32'(done_count - dc), 32'd0);
    last_sum = '0; last_cout = 1'b0;
    applyStimulus(8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0, 1'b0);

    repeat (2) @(negedge clk);
    checkOutput("scoreboard_empty", 32'(sbq.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
